// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   size_e  : access-size encodings carried on req_size
//   state_e : request-sequencing FSM states
//   ext8 / ext16 : load extension helpers (sign or zero)
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [31:0] ext8(input logic [7:0] val, input logic zero_ext);
    if (zero_ext) begin
      return {24'h000000, val};
    end else begin
      return {{24{val[7]}}, val};
    end
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] val, input logic zero_ext);
    if (zero_ext) begin
      return {16'h0000, val};
    end else begin
      return {{16{val[15]}}, val};
    end
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational lane alignment for the data-memory responder.
// Ports:
//   addr_lo_i    : byte offset within the word (addr[1:0])
//   size_i       : access size (byte / half / word / illegal)
//   unsigned_i   : zero-extend loads when 1, sign-extend when 0
//   wdata_i      : store data, significant bits in the low end
//   rword_i      : currently addressed array word
//   be_o         : per-byte write enables (all zero on a rejected access)
//   wdata_rep_o  : store data replicated onto every lane
//   rdata_o      : extended load result
//   access_err_o : misaligned or illegal-size access
module data_mem_responder_mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_o,
  output logic        access_err_o
);

  logic [7:0]  lane_byte_s;
  logic [15:0] lane_half_s;

  // Pick the addressed byte and half out of the word (little-endian lanes).
  always_comb begin
    lane_byte_s = 8'h00;
    case (addr_lo_i)
      2'b00:   lane_byte_s = rword_i[7:0];
      2'b01:   lane_byte_s = rword_i[15:8];
      2'b10:   lane_byte_s = rword_i[23:16];
      2'b11:   lane_byte_s = rword_i[31:24];
      default: lane_byte_s = 8'h00;
    endcase
    if (addr_lo_i[1]) begin
      lane_half_s = rword_i[31:16];
    end else begin
      lane_half_s = rword_i[15:0];
    end
  end

  // Decode size/offset into enables, replicated store data, load result and error.
  always_comb begin
    be_o         = 4'b0000;
    wdata_rep_o  = 32'h0000_0000;
    rdata_o      = 32'h0000_0000;
    access_err_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_o     = ext8(lane_byte_s, unsigned_i);
      end
      SZ_HALF: begin
        if (addr_lo_i[0]) begin
          access_err_o = 1'b1;
        end else begin
          be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_rep_o = {2{wdata_i[15:0]}};
          rdata_o     = ext16(lane_half_s, unsigned_i);
        end
      end
      SZ_WORD: begin
        if (addr_lo_i != 2'b00) begin
          access_err_o = 1'b1;
        end else begin
          be_o        = 4'b1111;
          wdata_rep_o = wdata_i;
          rdata_o     = rword_i;
        end
      end
      default: begin
        access_err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: serialises single load/store requests from the CPU
// datapath, holds the word array, and answers after a fixed latency.
// Ports:
//   clk, rst                 : clock (rising edge) and synchronous active-high reset
//   req_valid / req_ready    : request handshake, accepted on a rising edge in IDLE
//   req_write, req_addr, req_wdata, req_size, req_unsigned : request fields
//   resp_valid               : one-cycle response strobe
//   resp_rdata, resp_err     : load result / rejection flag, held until next commit
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (LATENCY < 4) ? 2 : $clog2(LATENCY + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, unsigned_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           mem_q [DEPTH];

  logic                  accept_s, commit_s;
  logic                  cur_write_s, cur_unsigned_s;
  logic [ADDR_WIDTH+1:0] cur_addr_s;
  logic [31:0]           cur_wdata_s;
  logic [1:0]            cur_size_s;
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [31:0]           rword_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_rep_s, load_data_s;
  logic                  access_err_s;
  logic                  unused_addr_s;

  // Upper address bits alias onto the array and are deliberately dropped.
  assign unused_addr_s = ^req_addr[31:ADDR_WIDTH+2];

  assign accept_s = (state_q == IDLE) && req_valid;
  // Only RESP is entered from IDLE/WAIT, so any transition into RESP is the
  // commit edge; reset vetoes it so an aborted request never writes.
  assign commit_s = (state_d == RESP) && !rst;

  // With LATENCY==1 the commit happens on the accepting edge itself, before the
  // request fields are latched, so in IDLE the live inputs are used directly.
  always_comb begin
    if (state_q == IDLE) begin
      cur_write_s    = req_write;
      cur_unsigned_s = req_unsigned;
      cur_addr_s     = req_addr[ADDR_WIDTH+1:0];
      cur_wdata_s    = req_wdata;
      cur_size_s     = req_size;
    end else begin
      cur_write_s    = write_q;
      cur_unsigned_s = unsigned_q;
      cur_addr_s     = addr_q;
      cur_wdata_s    = wdata_q;
      cur_size_s     = size_q;
    end
  end

  assign word_idx_s = cur_addr_s[ADDR_WIDTH+1:2];
  assign rword_s    = mem_q[word_idx_s];

  data_mem_responder_mem_lane_align u_align (
    .addr_lo_i    (cur_addr_s[1:0]),
    .size_i       (cur_size_s),
    .unsigned_i   (cur_unsigned_s),
    .wdata_i      (cur_wdata_s),
    .rword_i      (rword_s),
    .be_o         (be_s),
    .wdata_rep_o  (wdata_rep_s),
    .rdata_o      (load_data_s),
    .access_err_o (access_err_s)
  );

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = CNT_W'(LATENCY);
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(2)) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output next values, decoded from the next state so the ports come straight from flops.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (commit_s) begin
      resp_err_d = access_err_s;
      if (access_err_s || cur_write_s) begin
        resp_rdata_d = 32'h0000_0000;
      end else begin
        resp_rdata_d = load_data_s;
      end
    end else begin
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request capture on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      addr_q     <= {(ADDR_WIDTH + 2){1'b0}};
      wdata_q    <= 32'h0000_0000;
      size_q     <= 2'b00;
    end else if (accept_s) begin
      write_q    <= req_write;
      unsigned_q <= req_unsigned;
      addr_q     <= req_addr[ADDR_WIDTH+1:0];
      wdata_q    <= req_wdata;
      size_q     <= req_size;
    end
  end

  // Storage array: not reset; lane-masked write at the commit edge.
  always_ff @(posedge clk) begin
    if (commit_s && cur_write_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[word_idx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
